time_keeper_ctrl: RTL and testbench

Sequences the digital clock's time-of-day registers from the 1 Hz single-cycle sec_tick produced by the clock divider. It runs a small mode state machine (RUN / SET_HR / SET_MIN) driven by debounced single-cycle button pulses. It keeps HH:MM:SS in packed BCD for the display driver and emits a blink flag for the field being edited, plus a day-rollover pulse.

---
 rtl/clock_pkg.sv | 29 ++
 rtl/bcd2_counter.sv | 54 +++++
 rtl/time_keeper_ctrl.sv | 158 +++++++++++++++
 tb/tb_time_keeper_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// ============================================================================
// clock_pkg : shared mode encodings, BCD limits and helpers for the clock core
// Revision  : 1.0
// ============================================================================
`default_nettype none

package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10
  } mode_e;

  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;

  // Binary 0-99 to packed two-digit BCD; only used on elaboration constants.
  function automatic logic [7:0] bin2bcd(input int unsigned v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 10);
    units = 4'(v % 10);
    return {tens, units};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd2_counter.sv
// ============================================================================
// bcd2_counter : two-digit BCD counter with programmable wrap value and carry
// Revision     : 1.0
// ============================================================================
`default_nettype none

module bcd2_counter #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] max_i,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [7:0] count_o,
  output logic       carry_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;
  logic       w_at_max;

  assign w_at_max = (count_q == max_i);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'h00;
    end else if (inc_i) begin
      if (w_at_max) begin
        count_d = 8'h00;
      end else if (count_q[3:0] == 4'd9) begin
        count_d = {count_q[7:4] + 4'd1, 4'd0};
      end else begin
        count_d = {count_q[7:4], count_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  // Combinational so the next stage increments on the same edge as the wrap.
  assign carry_o = inc_i & ~clr_i & w_at_max;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/time_keeper_ctrl.sv
// ============================================================================
// time_keeper_ctrl : HH:MM:SS BCD timekeeping with RUN / SET_HR / SET_MIN modes
// Revision         : 1.0
// ============================================================================
`default_nettype none

module time_keeper_ctrl
  import clock_pkg::*;
#(
  parameter int RESET_HOUR    = 0,
  parameter int RESET_MIN     = 0,
  parameter int SET_TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
  output logic       blink,
  output logic       day_tick
);

  localparam logic [7:0] TMO_LIMIT = 8'(SET_TIMEOUT_S);

  mode_e      state_q, state_d;
  logic       blink_q, blink_d;
  logic       day_tick_q, day_tick_d;
  logic [7:0] tmo_q, tmo_d;

  logic w_run;
  logic w_sec_inc, w_sec_clr, w_sec_carry;
  logic w_min_inc, w_min_set_inc, w_min_carry;
  logic w_hr_inc, w_hr_set_inc, w_hr_carry;
  logic [7:0] w_tmo_next;

  assign w_run      = (state_q == MODE_RUN);
  assign w_tmo_next = tmo_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    blink_d       = blink_q;
    tmo_d         = tmo_q;
    w_sec_inc     = 1'b0;
    w_sec_clr     = 1'b0;
    w_min_set_inc = 1'b0;
    w_hr_set_inc  = 1'b0;
    case (state_q)
      MODE_RUN: begin
        blink_d = 1'b0;
        if (btn_mode) begin
          state_d = MODE_SET_HR;
          blink_d = 1'b1;
          tmo_d   = 8'd0;
        end else if (sec_tick) begin
          w_sec_inc = 1'b1;
        end
      end
      MODE_SET_HR, MODE_SET_MIN: begin
        if (btn_mode) begin
          tmo_d = 8'd0;
          if (state_q == MODE_SET_HR) begin
            state_d = MODE_SET_MIN;
            blink_d = 1'b1;
          end else begin
            state_d   = MODE_RUN;
            blink_d   = 1'b0;
            w_sec_clr = 1'b1;
          end
        end else begin
          if (btn_inc) begin
            tmo_d         = 8'd0;
            w_hr_set_inc  = (state_q == MODE_SET_HR);
            w_min_set_inc = (state_q == MODE_SET_MIN);
          end
          if (sec_tick) begin
            blink_d = ~blink_q;
            // An inc on the same tick restarts the idle window instead.
            if (!btn_inc) begin
              if (w_tmo_next == TMO_LIMIT) begin
                state_d   = MODE_RUN;
                blink_d   = 1'b0;
                tmo_d     = 8'd0;
                w_sec_clr = 1'b1;
              end else begin
                tmo_d = w_tmo_next;
              end
            end
          end
        end
      end
      default: begin
        state_d = MODE_RUN;
        blink_d = 1'b0;
        tmo_d   = 8'd0;
      end
    endcase
  end

  // Carries only ripple in RUN; set-mode increments wrap without carrying.
  assign w_min_inc  = w_sec_carry | w_min_set_inc;
  assign w_hr_inc   = (w_min_carry & w_run) | w_hr_set_inc;
  assign day_tick_d = w_hr_carry & w_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MODE_RUN;
      blink_q    <= 1'b0;
      day_tick_q <= 1'b0;
      tmo_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      blink_q    <= blink_d;
      day_tick_q <= day_tick_d;
      tmo_q      <= tmo_d;
    end
  end

  bcd2_counter #(.RESET_VAL(8'h00)) u_sec (
    .clk     (clk),
    .rst     (rst),
    .max_i   (BCD_59),
    .inc_i   (w_sec_inc),
    .clr_i   (w_sec_clr),
    .count_o (sec_bcd),
    .carry_o (w_sec_carry)
  );

  bcd2_counter #(.RESET_VAL(bin2bcd(RESET_MIN))) u_min (
    .clk     (clk),
    .rst     (rst),
    .max_i   (BCD_59),
    .inc_i   (w_min_inc),
    .clr_i   (1'b0),
    .count_o (min_bcd),
    .carry_o (w_min_carry)
  );

  bcd2_counter #(.RESET_VAL(bin2bcd(RESET_HOUR))) u_hour (
    .clk     (clk),
    .rst     (rst),
    .max_i   (BCD_23),
    .inc_i   (w_hr_inc),
    .clr_i   (1'b0),
    .count_o (hour_bcd),
    .carry_o (w_hr_carry)
  );

  assign mode     = state_q;
  assign blink    = blink_q;
  assign day_tick = day_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_time_keeper_ctrl.sv
// ============================================================================
// tb_time_keeper_ctrl : scoreboard bench comparing every cycle to a time model
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_time_keeper_ctrl;

  localparam int TMO = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sec_tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic [1:0] mode;
  logic       blink, day_tick;

  time_keeper_ctrl #(
    .RESET_HOUR    (0),
    .RESET_MIN     (0),
    .SET_TIMEOUT_S (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sec_tick (sec_tick),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .hour_bcd (hour_bcd),
    .min_bcd  (min_bcd),
    .sec_bcd  (sec_bcd),
    .mode     (mode),
    .blink    (blink),
    .day_tick (day_tick)
  );

  always #5 clk = ~clk;

  // Snapshot layout: {hour, min, sec, mode, blink, day_tick}
  typedef logic [27:0] snap_t;
  snap_t exp_q[$];
  snap_t obs_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model in plain binary arithmetic
  int m_hr, m_min, m_sec, m_mode, m_tmo;
  bit m_blink, m_day;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic snap_t model_snap();
    logic [1:0] md;
    md = 2'(m_mode);
    return {to_bcd(m_hr), to_bcd(m_min), to_bcd(m_sec), md, m_blink, m_day};
  endfunction

  function automatic snap_t dut_snap();
    return {hour_bcd, min_bcd, sec_bcd, mode, blink, day_tick};
  endfunction

  task automatic model_reset();
    m_hr = 0; m_min = 0; m_sec = 0; m_mode = 0; m_tmo = 0;
    m_blink = 0; m_day = 0;
  endtask

  task automatic model_step(input bit t, input bit m, input bit i);
    m_day = 0;
    if (m_mode == 0) begin
      m_blink = 0;
      if (m) begin
        m_mode = 1; m_blink = 1; m_tmo = 0;
      end else if (t) begin
        m_sec++;
        if (m_sec == 60) begin
          m_sec = 0; m_min++;
          if (m_min == 60) begin
            m_min = 0; m_hr++;
            if (m_hr == 24) begin
              m_hr = 0; m_day = 1;
            end
          end
        end
      end
    end else if (m) begin
      m_tmo = 0;
      if (m_mode == 1) begin
        m_mode = 2; m_blink = 1;
      end else begin
        m_mode = 0; m_blink = 0; m_sec = 0;
      end
    end else begin
      if (i) begin
        m_tmo = 0;
        if (m_mode == 1) m_hr = (m_hr + 1) % 24;
        else             m_min = (m_min + 1) % 60;
      end
      if (t) begin
        m_blink = !m_blink;
        if (!i) begin
          m_tmo++;
          if (m_tmo == TMO) begin
            m_mode = 0; m_blink = 0; m_sec = 0; m_tmo = 0;
          end
        end
      end
    end
  endtask

  // One clock of stimulus: predict, clock, then capture the DUT away from the edge.
  task automatic step(input bit t, input bit m, input bit i);
    sec_tick = t; btn_mode = m; btn_inc = i;
    model_step(t, m, i);
    exp_q.push_back(model_snap());
    @(posedge clk);
    #1;
    sec_tick = 0; btn_mode = 0; btn_inc = 0;
    obs_q.push_back(dut_snap());
  endtask

  // Asynchronous reset asserted away from any edge; outputs must change at once.
  task automatic async_reset();
    rst = 1'b1;
    model_reset();
    exp_q.push_back(model_snap());
    #2;
    obs_q.push_back(dut_snap());
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    async_reset();
    while (exp_q.size() > 0) begin
      snap_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset: got %h expected %h", o, e);
      end
    end
  endtask

  task automatic test_run_count();
    for (int k = 0; k < 61; k++) step(1, 0, 0);
    step(0, 0, 1);
    while (exp_q.size() > 0) begin
      snap_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL run_count: got %h expected %h", o, e);
      end
    end
    checks++;
    if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000101) begin
      errors++;
      $display("FAIL run_count_final: got %h expected 000101", {hour_bcd, min_bcd, sec_bcd});
    end
  endtask

  task automatic test_day_rollover();
    int day_seen;
    step(0, 1, 0);
    while (m_hr != 23) step(0, 0, 1);
    step(0, 1, 0);
    while (m_min != 59) step(0, 0, 1);
    step(0, 1, 0);
    for (int k = 0; k < 59; k++) step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    day_seen = 0;
    while (exp_q.size() > 0) begin
      snap_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o[0]) day_seen++;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL day_rollover: got %h expected %h", o, e);
      end
    end
    checks++;
    if (day_seen != 1) begin
      errors++;
      $display("FAIL day_tick_count: got %0d expected 1", day_seen);
    end
  endtask

  task automatic test_set_wrap();
    step(0, 1, 0);
    for (int k = 0; k < 25; k++) step(0, 0, 1);
    step(0, 1, 0);
    for (int k = 0; k < 61; k++) step(0, 0, 1);
    step(0, 1, 0);
    while (exp_q.size() > 0) begin
      snap_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL set_wrap: got %h expected %h", o, e);
      end
    end
    checks++;
    if ({hour_bcd, min_bcd} !== 16'h0101) begin
      errors++;
      $display("FAIL set_wrap_final: got %h expected 0101", {hour_bcd, min_bcd});
    end
  endtask

  task automatic test_blink();
    step(0, 1, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    while (exp_q.size() > 0) begin
      snap_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL blink: got %h expected %h", o, e);
      end
    end
  endtask

  task automatic test_timeout();
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    for (int k = 0; k < 4; k++) step(1, 0, 0);
    checks++;
    if (mode !== 2'b10) begin
      errors++;
      $display("FAIL timeout_early: got mode %b expected 10", mode);
    end
    step(1, 0, 0);
    while (exp_q.size() > 0) begin
      snap_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL timeout: got %h expected %h", o, e);
      end
    end
  endtask

  task automatic test_coincident();
    async_reset();
    for (int k = 0; k < 10; k++) step(1, 0, 0);
    step(1, 1, 0);
    step(0, 1, 1);
    step(0, 0, 1);
    step(1, 0, 0);
    #2;
    async_reset();
    step(1, 0, 0);
    while (exp_q.size() > 0) begin
      snap_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL coincident: got %h expected %h", o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0));
    end
    while (exp_q.size() > 0) begin
      snap_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back: got %h expected %h", o, e);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_count();
    test_day_rollover();
    test_set_wrap();
    test_blink();
    test_timeout();
    test_coincident();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
